// File: rtl/lpc_autocorr_engine.sv
// Frame autocorrelation R[0..ORDER] of signed PCM samples using one serial MAC.
// Each accepted sample occupies the engine for ORDER+3 cycles (ORDER+4 on the last sample of a frame).
// There is no backpressure: a sample strobed while busy is dropped and the sticky overrun flag is set.
// Ports: clk/rst (sync, active-high); x/x_valid sample input; frame_done pulse and r_flat frozen bank;
//        address/read/write/writedata/readdata 16-bit host register port (readdata registered).
module lpc_autocorr_engine #(
  parameter int DATA_W    = 16,
  parameter int ORDER     = 10,
  parameter int MAX_FRAME = 256,
  parameter int ACC_W     = 2*DATA_W + $clog2(MAX_FRAME)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            x,
  input  logic                         x_valid,
  output logic                         frame_done,
  output logic [(ORDER+1)*ACC_W-1:0]   r_flat,
  input  logic [15:0]                  address,
  input  logic                         read,
  input  logic                         write,
  input  logic [15:0]                  writedata,
  output logic [15:0]                  readdata
);

  localparam int LEN_W  = $clog2(MAX_FRAME+1);
  localparam int K_W    = $clog2(ORDER+1);
  localparam int PROD_W = 2*DATA_W;
  localparam logic [15:0]      MAX_FRAME_16 = 16'(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_RESET    = LEN_W'((MAX_FRAME < 240) ? MAX_FRAME : 240);

  typedef enum logic [1:0] {IDLE, SHIFT, MAC, COMMIT} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  x_cap;
  logic signed [DATA_W-1:0]  d    [0:ORDER];
  logic signed [ACC_W-1:0]   acc  [0:ORDER];
  logic signed [ACC_W-1:0]   bank [0:ORDER];
  logic [K_W-1:0]            k;
  logic [LEN_W-1:0]          count;
  logic [LEN_W-1:0]          count_nxt;
  logic [LEN_W-1:0]          frame_len;
  logic [5:0]                norm_shift;
  logic                      frame_ready;
  logic                      overrun;
  logic                      busy;

  // Register decode
  logic             len_wr;
  logic [LEN_W-1:0] len_wdata;
  logic             status_rd;

  assign busy      = (state != IDLE);
  assign count_nxt = count + 1'b1;
  assign len_wr    = write && (address == 16'h0) && (writedata != 16'h0);
  assign len_wdata = (writedata > MAX_FRAME_16) ? LEN_W'(MAX_FRAME) : writedata[LEN_W-1:0];
  assign status_rd = read && (address == 16'h1);

  // Full-precision product, sign-extended into the accumulator width
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  assign prod     = d[0] * d[k];
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Coefficient read path: arithmetic shift then saturate to 16 bits
  logic [15:0]             coef_off;
  logic                    coef_hit;
  logic signed [ACC_W-1:0] coef_sel;
  logic signed [ACC_W-1:0] coef_sh;
  logic [15:0]             coef_sat;
  logic [15:0]             rd_mux;

  assign coef_off = address - 16'h10;
  assign coef_hit = (address >= 16'h10) && (coef_off <= 16'(ORDER));
  assign coef_sel = bank[coef_off[K_W-1:0]];
  assign coef_sh  = coef_sel >>> norm_shift;

  always_comb begin
    coef_sat = coef_sh[15:0];
    // Upper bits must all match the sign bit for the value to fit in 16 bits
    if (!coef_sh[ACC_W-1] && (|coef_sh[ACC_W-2:15]))
      coef_sat = 16'h7FFF;
    else if (coef_sh[ACC_W-1] && !(&coef_sh[ACC_W-2:15]))
      coef_sat = 16'h8000;
  end

  always_comb begin
    rd_mux = 16'h0;
    case (address)
      16'h0:   rd_mux = 16'(frame_len);
      16'h1:   rd_mux = {13'b0, busy, overrun, frame_ready};
      16'h2:   rd_mux = {10'b0, norm_shift};
      default: if (coef_hit) rd_mux = coef_sat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x_cap       <= '0;
      k           <= '0;
      count       <= '0;
      frame_len   <= LEN_RESET;
      norm_shift  <= '0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      frame_done  <= 1'b0;
      readdata    <= '0;
      for (int i = 0; i <= ORDER; i++) begin
        d[i]    <= '0;
        acc[i]  <= '0;
        bank[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;

      if (write && (address == 16'h2))
        norm_shift <= writedata[5:0];

      if (len_wr) begin
        // New frame length aborts the frame in progress; bank keeps the last result
        frame_len <= len_wdata;
        state     <= IDLE;
        k         <= '0;
        count     <= '0;
        for (int i = 0; i <= ORDER; i++) begin
          d[i]   <= '0;
          acc[i] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (x_valid) begin
              x_cap <= x;
              state <= SHIFT;
            end
          end
          SHIFT: begin
            d[0] <= x_cap;
            for (int i = 1; i <= ORDER; i++)
              d[i] <= d[i-1];
            k     <= '0;
            state <= MAC;
          end
          MAC: begin
            acc[k] <= acc[k] + prod_ext;
            if (k == K_W'(ORDER)) begin
              k     <= '0;
              count <= count_nxt;
              state <= (count_nxt == frame_len) ? COMMIT : IDLE;
            end else begin
              k <= k + 1'b1;
            end
          end
          COMMIT: begin
            frame_done <= 1'b1;
            count      <= '0;
            state      <= IDLE;
            // Clearing the delay line keeps lags from reaching into the previous frame
            for (int i = 0; i <= ORDER; i++) begin
              bank[i] <= acc[i];
              acc[i]  <= '0;
              d[i]    <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Sticky flags: a set in the same cycle as the clearing read wins
      if (state == COMMIT && !len_wr)
        frame_ready <= 1'b1;
      else if (status_rd)
        frame_ready <= 1'b0;

      if (x_valid && busy)
        overrun <= 1'b1;
      else if (status_rd)
        overrun <= 1'b0;

      if (read)
        readdata <= rd_mux;
    end
  end

  for (genvar g = 0; g <= ORDER; g++) begin : g_flat
    assign r_flat[g*ACC_W +: ACC_W] = bank[g];
  end

endmodule

// File: tb/tb_lpc_autocorr_engine.sv
module tb_lpc_autocorr_engine;
  localparam int DATA_W    = 16;
  localparam int ORDER     = 10;
  localparam int MAX_FRAME = 256;
  localparam int ACC_W     = 2*DATA_W + $clog2(MAX_FRAME);
  localparam int SP        = 16;  // idle cycles after each sample strobe

  logic                       clk;
  logic                       rst;
  logic [DATA_W-1:0]          x;
  logic                       x_valid;
  logic                       frame_done;
  logic [(ORDER+1)*ACC_W-1:0] r_flat;
  logic [15:0]                address;
  logic                       read;
  logic                       write;
  logic [15:0]                writedata;
  logic [15:0]                readdata;

  lpc_autocorr_engine #(
    .DATA_W(DATA_W), .ORDER(ORDER), .MAX_FRAME(MAX_FRAME), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
    .frame_done(frame_done), .r_flat(r_flat),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues
  longint rd_exp_q[$];
  string  rd_name_q[$];
  longint bank_q[$];

  // Reference model state
  int     m_len = 240;
  int     m_shift = 0;
  longint m_bank [0:ORDER];
  int     m_frame[$];
  bit     m_ready = 0;
  bit     m_overrun = 0;
  int     frames_expected = 0;
  int     frames_seen = 0;

  logic   rd_d1 = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint get_r(input int k);
    logic signed [ACC_W-1:0] v;
    v = r_flat[k*ACC_W +: ACC_W];
    return longint'(v);
  endfunction

  function automatic longint to_u16_sat(input longint v);
    longint s;
    s = v;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return (s < 0) ? s + 65536 : s;
  endfunction

  // Autocorrelation of the accepted samples once a frame is complete
  task automatic model_sample(input int s);
    longint sum;
    m_frame.push_back(s);
    if (m_frame.size() == m_len) begin
      for (int k = 0; k <= ORDER; k++) begin
        sum = 0;
        for (int n = k; n < m_len; n++)
          sum += longint'(m_frame[n]) * longint'(m_frame[n-k]);
        m_bank[k] = sum;
        bank_q.push_back(sum);
      end
      m_frame.delete();
      m_ready = 1;
      frames_expected++;
    end
  endtask

  task automatic model_reset();
    m_len = 240;
    m_shift = 0;
    m_frame.delete();
    m_ready = 0;
    m_overrun = 0;
    for (int k = 0; k <= ORDER; k++) m_bank[k] = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input int a, input int dv);
    address = 16'(a);
    writedata = 16'(dv);
    write = 1'b1;
    step(1);
    write = 1'b0;
    if (a == 0 && dv != 0) begin
      m_len = (dv > MAX_FRAME) ? MAX_FRAME : dv;
      m_frame.delete();
    end
    if (a == 2) m_shift = dv & 63;
  endtask

  task automatic reg_rd(input int a, input longint exp, input string nm);
    address = 16'(a);
    read = 1'b1;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    step(1);
    read = 1'b0;
  endtask

  task automatic rd_status(input string nm);
    reg_rd(1, longint'({m_overrun, m_ready}), nm);
    m_ready = 0;
    m_overrun = 0;
  endtask

  task automatic rd_coefs(input string nm);
    for (int k = 0; k <= ORDER; k++)
      reg_rd(16 + k, to_u16_sat(m_bank[k] >>> m_shift), $sformatf("%s_r%0d", nm, k));
  endtask

  task automatic send(input int s);
    x = 16'(s);
    x_valid = 1'b1;
    step(1);
    x_valid = 1'b0;
    model_sample(s);
    step(SP);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  always @(posedge clk) rd_d1 <= read;

  always @(negedge clk) begin
    if (rd_d1) begin
      if (rd_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %0d expected no read data", readdata);
      end else begin
        check(rd_name_q.pop_front(), longint'(readdata), rd_exp_q.pop_front());
      end
    end
    if (frame_done) begin
      frames_seen++;
      if (bank_q.size() < ORDER + 1) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got pulse expected none (frame %0d)", frames_seen);
      end else begin
        for (int k = 0; k <= ORDER; k++)
          check($sformatf("r_flat_R%0d", k), get_r(k), bank_q.pop_front());
      end
    end
  end

  initial begin
    logic signed [15:0] rv;
    int len;

    rst = 1'b1; x = '0; x_valid = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    model_reset();
    step(3);
    rst = 1'b0;
    step(1);

    // Reset defaults
    check("rst_frame_done", longint'(frame_done), 0);
    check("rst_rflat_R0", get_r(0), 0);
    reg_rd(0, 240, "rst_frame_len");
    rd_status("rst_status");
    reg_rd(16, 0, "rst_coef0");
    reg_rd(2, 0, "rst_norm_shift");

    // Small frame then the reversed frame (boundary isolation)
    reg_wr(0, 4);
    reg_rd(0, 4, "len_readback");
    send(1); send(2); send(3); send(4);
    reg_rd(16, 30, "small_R0");
    reg_rd(17, 20, "small_R1");
    reg_rd(18, 11, "small_R2");
    rd_status("small_status1");
    rd_status("small_status2");
    send(4); send(3); send(2); send(1);
    reg_rd(17, 20, "iso_R1");
    rd_coefs("iso");
    check("frames_after_iso", frames_seen, frames_expected);

    // Overrun: second strobe two cycles later lands while busy
    x = 16'(5); x_valid = 1'b1; step(1); x_valid = 1'b0;
    step(1);
    x = 16'(77); x_valid = 1'b1; step(1); x_valid = 1'b0;
    model_sample(5);
    m_overrun = 1;
    step(SP);
    send(-6); send(7);
    check("overrun_no_early_frame", frames_seen, frames_expected);
    send(-8);
    rd_coefs("ovr");
    rd_status("ovr_status1");
    rd_status("ovr_status2");

    // Abort and clamp
    send(9); send(-7);
    reg_wr(0, 4);
    send(1); send(2); send(3); send(4);
    reg_rd(16, 30, "abort_R0");
    reg_rd(17, 20, "abort_R1");
    reg_rd(18, 11, "abort_R2");
    reg_wr(0, 0);
    reg_rd(0, 4, "len_write0_ignored");
    reg_wr(0, 1000);
    reg_rd(0, 256, "len_clamp");
    reg_wr(2, 16'hFFC5);
    reg_rd(2, 5, "norm_shift_mask");
    reg_wr(1, 16'hFFFF);
    reg_rd(5, 0, "unmapped_5");
    reg_rd(16 + ORDER + 1, 0, "unmapped_past_bank");
    rd_status("status_ro");

    // Saturation and shift on a full-scale 240-sample frame
    reg_wr(0, 240);
    reg_wr(2, 0);
    for (int i = 0; i < 240; i++) send(-32768);
    check("sat_R0", get_r(0), 64'd257698037760);
    reg_rd(16, 16'h7FFF, "sat_shift0");
    reg_wr(2, 24);
    reg_rd(16, 15360, "sat_shift24");
    rd_coefs("sat");

    // Randomised frames
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(5, 14);
      reg_wr(0, len);
      for (int i = 0; i < len; i++) begin
        rv = 16'($urandom);
        send(int'(rv));
      end
      reg_wr(2, $urandom_range(0, 40));
      rd_coefs($sformatf("rand%0d", f));
      rd_status($sformatf("rand%0d_status", f));
    end

    // Reset in the middle of a MAC sequence
    reg_wr(0, 4);
    x = 16'(123); x_valid = 1'b1; step(1); x_valid = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k <= ORDER; k++)
      check($sformatf("midrst_rflat_R%0d", k), get_r(k), 0);
    check("midrst_frame_done", longint'(frame_done), 0);
    reg_rd(0, 240, "midrst_frame_len");
    reg_rd(2, 0, "midrst_norm_shift");
    rd_status("midrst_status");
    reg_wr(0, 4);
    send(1); send(2); send(3); send(4);
    rd_coefs("post_rst");

    // Drain with a bounded wait
    for (int i = 0; i < 200 && (bank_q.size() != 0 || rd_exp_q.size() != 0); i++) step(1);
    check("pending_banks", bank_q.size(), 0);
    check("pending_reads", rd_exp_q.size(), 0);
    check("frame_count", frames_seen, frames_expected);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
